// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings and default latencies for the multiply/divide unit
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;
    localparam logic [2:0] OP_MSUBU = 3'b111;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/muldiv_divcore.sv
// rtl/muldiv_divcore.sv - combinational signed/unsigned divider with zero-divisor and overflow fix-up
module muldiv_divcore #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;

    always_comb begin
        neg_a = is_signed && dividend[WIDTH-1];
        neg_b = is_signed && divisor[WIDTH-1];
        mag_a = neg_a ? -dividend : dividend;
        mag_b = neg_b ? -divisor : divisor;
        uq    = '0;
        ur    = '0;
        if (mag_b != '0) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        // Truncation toward zero: quotient sign from both operands, remainder follows the dividend.
        quotient  = (neg_a ^ neg_b) ? -uq : uq;
        remainder = neg_a ? -ur : ur;
        if (divisor == '0) begin
            quotient  = '1;
            remainder = dividend;
        end else if (is_signed && dividend == MIN_NEG && divisor == '1) begin
            quotient  = MIN_NEG;
            remainder = '0;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - cancellable multiply/divide unit with HI/LO; MULDIV_MADD_EN enables accumulate ops
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   pend_hi;
    logic [WIDTH-1:0]   pend_lo;
    logic               is_div;
    logic               op_legal;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    muldiv_divcore #(.WIDTH(WIDTH)) u_divcore (
        .dividend  (d1),
        .divisor   (d2),
        .is_signed (~op[0]),
        .quotient  (quo),
        .remainder (rem)
    );

    assign busy   = (cnt != '0);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

`ifdef MULDIV_MADD_EN
    assign op_legal = 1'b1;
`else
    assign op_legal = !(op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
`endif

    // op[0] marks the unsigned variant across every op class.
    always_comb begin
        ext_a  = op[0] ? {{WIDTH{1'b0}}, d1} : {{WIDTH{d1[WIDTH-1]}}, d1};
        ext_b  = op[0] ? {{WIDTH{1'b0}}, d2} : {{WIDTH{d2[WIDTH-1]}}, d2};
        prod   = ext_a * ext_b;
        result = prod;
        case (op)
            OP_DIV, OP_DIVU: result = {rem, quo};
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU: result = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: result = {hi, lo} - prod;
`endif
            default: ;
        endcase
    end

    // Result is parked in pend_* and only reaches HI/LO on an uncancelled final count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                if (cancel) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hi   <= pend_hi;
                        lo   <= pend_lo;
                        done <= 1'b1;
                    end
                end
            end else if (!cancel) begin
                if (start) begin
                    if (op_legal) begin
                        cnt     <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                        pend_hi <= result[2*WIDTH-1:WIDTH];
                        pend_lo <= result[WIDTH-1:0];
                    end
                end else if (hilo_we) begin
                    if (hilo_sel) hi <= d1;
                    else          lo <= d1;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic        hilo_we = 1'b0;
    logic        hilo_sel = 1'b0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_miss = 0;

    muldiv_unit dut (
        .clk      (clk),
        .rst      (rst_n),
        .start    (start),
        .op       (op),
        .d1       (d1),
        .d2       (d2),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_hilo(input logic sel, input logic [31:0] val);
        @(negedge clk);
        hilo_we  = 1'b1;
        hilo_sel = sel;
        d1       = val;
        @(negedge clk);
        hilo_we  = 1'b0;
    endtask

    // Issue one op, then watch a fixed window counting busy cycles and done pulses.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy, input int exp_done,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int nb;
        int nd;
        nb = 0;
        nd = 0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        d1    = a;
        d2    = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (busy) nb++;
            if (done) nd++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(nb), 64'(exp_busy));
        check({tag, " done_pulses"}, 64'(nd), 64'(exp_done));
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int nd;
        repeat (3) @(negedge clk);
        check("reset hi", 64'(hi), 64'h0);
        check("reset lo", 64'(lo), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset done", 64'(done), 64'h0);
        rst_n = 1'b1;

        run_op("mult",    3'b000, 32'hFFFF_FFFE, 32'd3, 5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu",   3'b001, 32'hFFFF_FFFE, 32'd3, 5, 1, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("divu",    3'b011, 32'd100,       32'd7, 10, 1, 32'd2, 32'd14);
        run_op("div neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 10, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div by0", 3'b010, 32'd5,         32'd0, 10, 1, 32'd5, 32'hFFFF_FFFF);
        run_op("divu by0", 3'b011, 32'd9,        32'd0, 10, 1, 32'd9, 32'hFFFF_FFFF);
        run_op("div ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1, 32'h0, 32'h8000_0000);

        // Cancel in busy cycle 3.
        write_hilo(1'b1, 32'h11);
        write_hilo(1'b0, 32'h22);
        @(negedge clk);
        start = 1'b1; op = 3'b000; d1 = 32'd3; d2 = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel mid busy", 64'(busy), 64'h0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("cancel mid done", 64'(nd), 64'h0);
        check("cancel mid hi", 64'(hi), 64'h11);
        check("cancel mid lo", 64'(lo), 64'h22);

        // Cancel on the final count.
        @(negedge clk);
        start = 1'b1; op = 3'b000; d1 = 32'd3; d2 = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("cancel last still busy", 64'(busy), 64'h1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel last busy", 64'(busy), 64'h0);
        check("cancel last done", 64'(done), 64'h0);
        check("cancel last hi", 64'(hi), 64'h11);
        check("cancel last lo", 64'(lo), 64'h22);

        // Cancel while idle drops start.
        start = 1'b1; cancel = 1'b1; op = 3'b001; d1 = 32'd2; d2 = 32'd2;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel idle busy", 64'(busy), 64'h0);

        write_hilo(1'b1, 32'h0);
        write_hilo(1'b0, 32'hFFFF_FFFF);
`ifdef MULDIV_MADD_EN
        run_op("maddu", 3'b101, 32'd1, 32'd1, 5, 1, 32'h1, 32'h0);
`else
        run_op("maddu off", 3'b101, 32'd1, 32'd1, 0, 0, 32'h0, 32'hFFFF_FFFF);
`endif

        // hilo_we during busy is ignored.
        write_hilo(1'b1, 32'h55);
        @(negedge clk);
        start = 1'b1; op = 3'b001; d1 = 32'd2; d2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        hilo_we = 1'b1; hilo_sel = 1'b0; d1 = 32'hDEAD;
        @(negedge clk);
        hilo_we = 1'b0;
        check("we busy hi hold", 64'(hi), 64'h55);
        repeat (8) @(negedge clk);
        check("we busy hi", 64'(hi), 64'h0);
        check("we busy lo", 64'(lo), 64'h6);

        // start with hilo_we while idle: only the op commits.
        write_hilo(1'b1, 32'h77);
        @(negedge clk);
        start = 1'b1; hilo_we = 1'b1; hilo_sel = 1'b1; op = 3'b001; d1 = 32'd5; d2 = 32'd5;
        @(negedge clk);
        start = 1'b0; hilo_we = 1'b0;
        check("start+we hi untouched", 64'(hi), 64'h77);
        repeat (8) @(negedge clk);
        check("start+we hi", 64'(hi), 64'h0);
        check("start+we lo", 64'(lo), 64'd25);

        // Reset mid-divide.
        @(negedge clk);
        start = 1'b1; op = 3'b011; d1 = 32'd100; d2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        check("async reset hi", 64'(hi), 64'h0);
        check("async reset lo", 64'(lo), 64'h0);
        check("async reset busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("post-reset done", 64'(nd), 64'h0);
        check("post-reset lo", 64'(lo), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
